// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first, with valid/ready
// handshakes on both the operand and result sides.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q;
    logic             fa_sum, fa_cout;
    logic             accept, last_bit;

    // The single full-adder cell, fed from the operand shift registers and carry flop.
    assign fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_cout = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StRun;
            StRun:  if (last_bit) state_d = StDone;
            StDone: if (out_ready) state_d = in_valid ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: in_ready = 1'b1;
            StRun:  in_ready = 1'b0;
            StDone: begin
                // Accepting a new pair only as the held result leaves keeps it stable.
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_sr_q  <= in_a;
            b_sr_q  <= in_b;
            carry_q <= in_cin;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            a_sr_q  <= a_sr_q >> 1;
            b_sr_q  <= b_sr_q >> 1;
            // After WIDTH shifts the first sum bit has reached bit 0.
            sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
            carry_q <= fa_cout;
            if (last_bit) begin
                cout_q <= fa_cout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign out_sum  = sum_q;
    assign out_cout = cout_q;

endmodule
